// File: rtl/vpifo_ingress_pkg.sv
// Shared types and default sizing for the vPIFO command ingress stage.
// Payload/tree widths are fixed here so the command struct can live in the package.
package vpifo_ingress_pkg;

  localparam int PTW      = 16;
  localparam int MTW      = 0;
  localparam int DW       = MTW + PTW;
  localparam int TREE_NUM = 4;

  localparam int CMD_DEPTH_DEF   = 4;
  localparam int BACKOFF_CYC_DEF = 2;
  localparam int MAX_RETRY_DEF   = 3;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TNB    = idx_w(TREE_NUM);
  localparam int CMD_AW = idx_w(CMD_DEPTH_DEF);

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic {
    ISSUE   = 1'b0,
    BACKOFF = 1'b1
  } fsm_t;

  typedef struct packed {
    logic           op;
    logic [TNB-1:0] tree_id;
    logic [DW-1:0]  data;
  } cmd_t;

endpackage

// File: rtl/vpifo_cmd_ingress_if.sv
// Host command handshake plus IO-port strobe bus for the ingress stage.
// VPIFO_INGRESS_STATS_EN adds the three 16-bit statistics counters.
interface vpifo_cmd_ingress_if;
  import vpifo_ingress_pkg::*;

  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_op;
  logic [TNB-1:0] cmd_tree_id;
  logic [DW-1:0]  cmd_data;

  logic [TNB-1:0] tree_id;
  logic           push;
  logic [DW-1:0]  push_data;
  logic           pop;
  logic           task_fail;

  logic           drop;
  logic [TNB-1:0] drop_tree_id;
  logic           busy;

`ifdef VPIFO_INGRESS_STATS_EN
  logic [15:0]    stat_issued;
  logic [15:0]    stat_retries;
  logic [15:0]    stat_drops;

  modport master (
    output cmd_valid, cmd_op, cmd_tree_id, cmd_data, task_fail,
    input  cmd_ready, tree_id, push, push_data, pop, drop, drop_tree_id, busy,
    input  stat_issued, stat_retries, stat_drops
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_tree_id, cmd_data, task_fail,
    output cmd_ready, tree_id, push, push_data, pop, drop, drop_tree_id, busy,
    output stat_issued, stat_retries, stat_drops
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_tree_id, cmd_data, task_fail,
    input  cmd_ready, tree_id, push, push_data, pop, drop, drop_tree_id, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_tree_id, cmd_data, task_fail,
    output cmd_ready, tree_id, push, push_data, pop, drop, drop_tree_id, busy
  );
`endif

endinterface

// File: rtl/vpifo_cmd_fifo.sv
// Command FIFO with head-register read: 1-cycle write-to-head latency.
// Writes refused while full (even with a same-cycle read); reads ignored while empty.
module vpifo_cmd_fifo
  import vpifo_ingress_pkg::*;
#(
  parameter int DEPTH = CMD_DEPTH_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_arst_n,
  input  logic                    wr,
  input  cmd_t                    wr_cmd,
  input  logic                    rd,
  output cmd_t                    head,
  output logic                    full,
  output logic                    empty,
  output logic [idx_w(DEPTH):0]   count
);

  localparam int AW = idx_w(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_wr;
  logic          do_rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_cmd;
  end

endmodule

// File: rtl/vpifo_cmd_ingress.sv
// vPIFO IO-port ingress: buffers host push/pop commands, issues one per cycle, retries on task-fail
// with fixed backoff and drops after MAX_RETRY attempts. VPIFO_INGRESS_STATS_EN adds stat counters.
module vpifo_cmd_ingress
  import vpifo_ingress_pkg::*;
#(
  parameter int CMD_DEPTH   = CMD_DEPTH_DEF,
  parameter int BACKOFF_CYC = BACKOFF_CYC_DEF,
  parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
  input logic                i_clk,
  input logic                i_arst_n,
  vpifo_cmd_ingress_if.slave bus
);

  localparam int CAW = idx_w(CMD_DEPTH);
  localparam int RCW = idx_w(MAX_RETRY + 1);
  localparam int BCW = idx_w(BACKOFF_CYC + 1);

  cmd_t           wr_cmd;
  cmd_t           head;
  logic           full;
  logic           empty;
  logic [CAW:0]   count;
  logic           deq;

  fsm_t           state;
  logic [RCW-1:0] retry_cnt;
  logic [BCW-1:0] backoff_cnt;

  logic           attempt;
  logic           issue;
  logic           fail;
  logic           last_fail;

  assign wr_cmd = '{op: bus.cmd_op, tree_id: bus.cmd_tree_id, data: bus.cmd_data};

  vpifo_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .wr       (bus.cmd_valid),
    .wr_cmd   (wr_cmd),
    .rd       (deq),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // task_fail is sampled in the same cycle a strobe would go out, so a failing
  // cycle never carries a strobe.
  always_comb begin
    attempt   = (state == ISSUE) && !empty;
    issue     = attempt && !bus.task_fail;
    fail      = attempt && bus.task_fail;
    last_fail = fail && (retry_cnt == RCW'(MAX_RETRY - 1));
    deq       = issue || last_fail;
  end

  assign bus.cmd_ready    = !full;
  assign bus.tree_id      = empty ? '0 : head.tree_id;
  assign bus.push_data    = empty ? '0 : head.data;
  assign bus.push         = issue && (head.op == OP_PUSH);
  assign bus.pop          = issue && (head.op == OP_POP);
  assign bus.drop         = last_fail;
  assign bus.drop_tree_id = last_fail ? head.tree_id : '0;
  assign bus.busy         = (count != '0) || (state != ISSUE);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state       <= ISSUE;
      retry_cnt   <= '0;
      backoff_cnt <= '0;
    end else begin
      case (state)
        ISSUE: begin
          if (issue || last_fail) begin
            retry_cnt <= '0;
          end else if (fail) begin
            retry_cnt   <= retry_cnt + RCW'(1);
            backoff_cnt <= BCW'(BACKOFF_CYC);
            state       <= BACKOFF;
          end
        end
        BACKOFF: begin
          backoff_cnt <= backoff_cnt - BCW'(1);
          if (backoff_cnt == BCW'(1)) state <= ISSUE;
        end
      endcase
    end
  end

`ifdef VPIFO_INGRESS_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_retries;
  logic [15:0] stat_drops;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      stat_issued  <= '0;
      stat_retries <= '0;
      stat_drops   <= '0;
    end else begin
      if (issue && (stat_issued != '1))      stat_issued  <= stat_issued + 16'd1;
      if (fail && (stat_retries != '1))      stat_retries <= stat_retries + 16'd1;
      if (last_fail && (stat_drops != '1))   stat_drops   <= stat_drops + 16'd1;
    end
  end

  assign bus.stat_issued  = stat_issued;
  assign bus.stat_retries = stat_retries;
  assign bus.stat_drops   = stat_drops;
`endif

endmodule

// File: tb/tb_vpifo_cmd_ingress.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_vpifo_cmd_ingress;
  import vpifo_ingress_pkg::*;

  localparam int CMD_DEPTH   = 4;
  localparam int BACKOFF_CYC = 2;
  localparam int MAX_RETRY   = 3;
  localparam int N_RAND      = 4000;

  logic clk;
  logic arst_n;

  vpifo_cmd_ingress_if bus();

  vpifo_cmd_ingress #(
    .CMD_DEPTH   (CMD_DEPTH),
    .BACKOFF_CYC (BACKOFF_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .i_clk    (clk),
    .i_arst_n (arst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           ready;
    logic           push;
    logic           pop;
    logic [TNB-1:0] tree;
    logic [DW-1:0]  data;
    logic           drop;
    logic [TNB-1:0] dtree;
    logic           busy;
  } exp_t;

  typedef struct {
    logic           rst;
    logic           valid;
    logic           op;
    logic [TNB-1:0] tree;
    logic [DW-1:0]  data;
    logic           tf;
    exp_t           e;
  } vec_t;

  int n_err;
  int n_checks;
  vec_t tbl [0:34];

  function automatic vec_t row(input int rst, valid, op, tree, data, tf,
                               input int ready, push, pop, etree, edata, drop, dtree, busy);
    vec_t r;
    r.rst     = 1'(rst);
    r.valid   = 1'(valid);
    r.op      = 1'(op);
    r.tree    = TNB'(tree);
    r.data    = DW'(data);
    r.tf      = 1'(tf);
    r.e.ready = 1'(ready);
    r.e.push  = 1'(push);
    r.e.pop   = 1'(pop);
    r.e.tree  = TNB'(etree);
    r.e.data  = DW'(edata);
    r.e.drop  = 1'(drop);
    r.e.dtree = TNB'(dtree);
    r.e.busy  = 1'(busy);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic valid, input logic op,
                       input logic [TNB-1:0] tree, input logic [DW-1:0] data, input logic tf);
    arst_n          = !rst;
    bus.cmd_valid   = valid;
    bus.cmd_op      = op;
    bus.cmd_tree_id = tree;
    bus.cmd_data    = data;
    bus.task_fail   = tf;
  endtask

  task automatic check_outs(input exp_t e);
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(e.ready));
    chk("push",      32'(bus.push),      32'(e.push));
    chk("pop",       32'(bus.pop),       32'(e.pop));
    chk("tree_id",   32'(bus.tree_id),   32'(e.tree));
    chk("push_data", 32'(bus.push_data), 32'(e.data));
    chk("drop",      32'(bus.drop),      32'(e.drop));
    chk("busy",      32'(bus.busy),      32'(e.busy));
    if (e.drop) chk("drop_tree_id", 32'(bus.drop_tree_id), 32'(e.dtree));
  endtask

  // Each row: inputs applied just after a rising edge, outputs sampled mid-cycle.
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].op, tbl[i].tree, tbl[i].data, tbl[i].tf);
      #3;
      check_outs(tbl[i].e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_stats(input int issued, input int retries, input int drops);
`ifdef VPIFO_INGRESS_STATS_EN
    chk("stat_issued",  32'(bus.stat_issued),  32'(issued));
    chk("stat_retries", 32'(bus.stat_retries), 32'(retries));
    chk("stat_drops",   32'(bus.stat_drops),   32'(drops));
`else
    if (issued < 0 || retries < 0 || drops < 0) chk("stat_args", 32'(issued), 32'(0));
`endif
  endtask

  cmd_t q[$];
  int   fails;
  int   next_try;
  int   m_issued;
  int   m_retries;
  int   m_drops;

  initial begin
    n_err    = 0;
    n_checks = 0;
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

    //             rst v op tr data     tf   rdy psh pop tr data     drp dtr busy
    tbl[0]  = row(1, 0, 0, 0, 'h0000, 0,   1, 0, 0, 0, 'h0000, 0, 0, 0);
    // back-to-back push, push, pop
    tbl[1]  = row(0, 1, 0, 1, 'h00AA, 0,   1, 0, 0, 0, 'h0000, 0, 0, 0);
    tbl[2]  = row(0, 1, 0, 2, 'h00BB, 0,   1, 1, 0, 1, 'h00AA, 0, 0, 1);
    tbl[3]  = row(0, 1, 1, 1, 'h0000, 0,   1, 1, 0, 2, 'h00BB, 0, 0, 1);
    tbl[4]  = row(0, 0, 0, 0, 'h0000, 0,   1, 0, 1, 1, 'h0000, 0, 0, 1);
    tbl[5]  = row(0, 0, 0, 0, 'h0000, 0,   1, 0, 0, 0, 'h0000, 0, 0, 0);
    // single retry: fail, two backoff cycles, then strobe
    tbl[6]  = row(0, 1, 0, 3, 'h1234, 0,   1, 0, 0, 0, 'h0000, 0, 0, 0);
    tbl[7]  = row(0, 0, 0, 0, 'h0000, 1,   1, 0, 0, 3, 'h1234, 0, 0, 1);
    tbl[8]  = row(0, 0, 0, 0, 'h0000, 1,   1, 0, 0, 3, 'h1234, 0, 0, 1);
    tbl[9]  = row(0, 0, 0, 0, 'h0000, 0,   1, 0, 0, 3, 'h1234, 0, 0, 1);
    tbl[10] = row(0, 0, 0, 0, 'h0000, 0,   1, 1, 0, 3, 'h1234, 0, 0, 1);
    tbl[11] = row(0, 0, 0, 0, 'h0000, 0,   1, 0, 0, 0, 'h0000, 0, 0, 0);
    // drop after three attempts, next command becomes head
    tbl[12] = row(0, 1, 0, 2, 'h0101, 1,   1, 0, 0, 0, 'h0000, 0, 0, 0);
    tbl[13] = row(0, 1, 0, 1, 'h0202, 1,   1, 0, 0, 2, 'h0101, 0, 0, 1);
    tbl[14] = row(0, 0, 0, 0, 'h0000, 1,   1, 0, 0, 2, 'h0101, 0, 0, 1);
    tbl[15] = row(0, 0, 0, 0, 'h0000, 1,   1, 0, 0, 2, 'h0101, 0, 0, 1);
    tbl[16] = row(0, 0, 0, 0, 'h0000, 1,   1, 0, 0, 2, 'h0101, 0, 0, 1);
    tbl[17] = row(0, 0, 0, 0, 'h0000, 1,   1, 0, 0, 2, 'h0101, 0, 0, 1);
    tbl[18] = row(0, 0, 0, 0, 'h0000, 1,   1, 0, 0, 2, 'h0101, 0, 0, 1);
    tbl[19] = row(0, 0, 0, 0, 'h0000, 1,   1, 0, 0, 2, 'h0101, 1, 2, 1);
    tbl[20] = row(0, 0, 0, 0, 'h0000, 0,   1, 1, 0, 1, 'h0202, 0, 0, 1);
    tbl[21] = row(0, 0, 0, 0, 'h0000, 0,   1, 0, 0, 0, 'h0000, 0, 0, 0);
    // full FIFO: six offers under permanent task-fail, four accepted
    tbl[22] = row(0, 1, 0, 1, 'h0010, 1,   1, 0, 0, 0, 'h0000, 0, 0, 0);
    tbl[23] = row(0, 1, 0, 2, 'h0011, 1,   1, 0, 0, 1, 'h0010, 0, 0, 1);
    tbl[24] = row(0, 1, 0, 3, 'h0012, 1,   1, 0, 0, 1, 'h0010, 0, 0, 1);
    tbl[25] = row(0, 1, 0, 0, 'h0013, 1,   1, 0, 0, 1, 'h0010, 0, 0, 1);
    tbl[26] = row(0, 1, 0, 1, 'h0014, 1,   0, 0, 0, 1, 'h0010, 0, 0, 1);
    tbl[27] = row(0, 1, 0, 2, 'h0015, 1,   0, 0, 0, 1, 'h0010, 0, 0, 1);
    tbl[28] = row(0, 0, 0, 0, 'h0000, 1,   0, 0, 0, 1, 'h0010, 0, 0, 1);
    tbl[29] = row(0, 0, 0, 0, 'h0000, 1,   0, 0, 0, 1, 'h0010, 1, 1, 1);
    tbl[30] = row(0, 1, 0, 3, 'h0099, 1,   1, 0, 0, 2, 'h0011, 0, 0, 1);
    // reset with commands queued, then a fresh command issues normally
    tbl[31] = row(1, 0, 0, 0, 'h0000, 1,   1, 0, 0, 0, 'h0000, 0, 0, 0);
    tbl[32] = row(0, 1, 0, 2, 'h0AB0, 0,   1, 0, 0, 0, 'h0000, 0, 0, 0);
    tbl[33] = row(0, 0, 0, 0, 'h0000, 0,   1, 1, 0, 2, 'h0AB0, 0, 0, 1);
    tbl[34] = row(0, 0, 0, 0, 'h0000, 0,   1, 0, 0, 0, 'h0000, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    run_rows(0, 21);
    check_stats(5, 4, 1);
    run_rows(22, 34);
    check_stats(1, 0, 0);

    // Randomized phase against the reference model.
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    q.delete();
    fails     = 0;
    next_try  = 0;
    m_issued  = 0;
    m_retries = 0;
    m_drops   = 0;

    for (int c = 0; c < N_RAND; c++) begin
      logic           v;
      logic           op;
      logic [TNB-1:0] tree;
      logic [DW-1:0]  data;
      logic           tf;
      logic           in_issue;
      logic           deq;
      int             pct;
      exp_t           e;
      cmd_t           nc;

      case ((c / 400) % 3)
        0:       pct = 10;
        1:       pct = 50;
        default: pct = 85;
      endcase
      v    = ($urandom_range(99) < 60);
      op   = 1'($urandom_range(1));
      tree = TNB'($urandom_range(TREE_NUM - 1));
      data = op ? '0 : DW'($urandom);
      tf   = ($urandom_range(99) < pct);

      e.ready  = (q.size() < CMD_DEPTH);
      in_issue = (c >= next_try);
      e.busy   = (q.size() != 0) || !in_issue;
      e.push   = 1'b0;
      e.pop    = 1'b0;
      e.drop   = 1'b0;
      e.dtree  = '0;
      e.tree   = '0;
      e.data   = '0;
      deq      = 1'b0;
      if (q.size() != 0) begin
        e.tree = q[0].tree_id;
        e.data = q[0].data;
        if (in_issue) begin
          if (!tf) begin
            e.push = (q[0].op == OP_PUSH);
            e.pop  = (q[0].op == OP_POP);
            deq    = 1'b1;
            fails  = 0;
            m_issued++;
          end else begin
            m_retries++;
            fails++;
            if (fails == MAX_RETRY) begin
              e.drop  = 1'b1;
              e.dtree = q[0].tree_id;
              deq     = 1'b1;
              fails   = 0;
              m_drops++;
            end else begin
              next_try = c + BACKOFF_CYC + 1;
            end
          end
        end
      end

      drive(1'b0, v, op, tree, data, tf);
      #3;
      check_outs(e);

      if (deq) void'(q.pop_front());
      if (v && e.ready) begin
        nc.op      = op;
        nc.tree_id = tree;
        nc.data    = data;
        q.push_back(nc);
      end
      @(posedge clk);
      #1;
    end

    check_stats(m_issued, m_retries, m_drops);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
